// File: rtl/instruction_memory.sv
// Byte-loadable instruction memory for the IF stage: the debug unit streams bytes
// MSB-first into a flat byte array, and the word at i_pc is read combinationally.
module instruction_memory #(
  parameter int PC_SIZE            = 32,
  parameter int BYTE_SIZE          = 8,
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  localparam int WORD_SIZE         = BYTE_SIZE * WORD_SIZE_IN_BYTES,
  localparam int MEM_BYTES         = MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES,
  localparam int PTR_W             = $clog2(MEM_BYTES) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_write,
  input  logic [BYTE_SIZE-1:0] i_data,
  input  logic [PC_SIZE-1:0]   i_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [PTR_W-1:0]     o_word_count
);

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int BOFS_W = $clog2(WORD_SIZE_IN_BYTES);
  localparam int WIDX_W = $clog2(MEM_SIZE_IN_WORDS);

  logic [BYTE_SIZE-1:0] r_mem [MEM_BYTES];
  logic [PTR_W-1:0]     r_wr_ptr;

  logic                 w_full;
  logic [PC_SIZE-3:0]   w_pc_word;
  logic [WIDX_W-1:0]    w_word_idx;
  logic                 w_in_range;
  logic                 w_unused_pc_lsb;

  assign w_full = (r_wr_ptr == PTR_W'(MEM_BYTES));

  // Writes saturate at full: no wrap-around, extra bytes are dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < MEM_BYTES; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < MEM_BYTES; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (i_write && !w_full) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  assign w_pc_word       = i_pc[PC_SIZE-1:2];
  assign w_word_idx      = w_pc_word[WIDX_W-1:0];
  assign w_in_range      = (w_pc_word < (PC_SIZE-2)'(MEM_SIZE_IN_WORDS));
  assign w_unused_pc_lsb = ^i_pc[1:0];

  // Byte 0 of a word lands in the most significant lane (big-endian).
  generate
    for (genvar gi = 0; gi < WORD_SIZE_IN_BYTES; gi++) begin : g_lane
      assign o_instruction[WORD_SIZE-1-gi*BYTE_SIZE -: BYTE_SIZE] =
        w_in_range ? r_mem[{w_word_idx, BOFS_W'(gi)}] : '0;
    end
  endgenerate

  assign o_full       = w_full;
  assign o_empty      = (r_wr_ptr == '0);
  assign o_word_count = r_wr_ptr >> BOFS_W;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized self-checking bench for instruction_memory against a byte-queue model.
module tb_instruction_memory;

  localparam int MEM_BYTES = 256;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clear;
  logic        i_write;
  logic [7:0]  i_data;
  logic [31:0] i_pc;
  logic [31:0] o_instruction;
  logic        o_full;
  logic        o_empty;
  logic [8:0]  o_word_count;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [7:0] model_q[$];

  instruction_memory dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_write       (i_write),
    .i_data        (i_data),
    .i_pc          (i_pc),
    .o_instruction (o_instruction),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_word_count  (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    logic [31:0] w;
    int base;
    w = 32'h0;
    if ((pc >> 2) < 64) begin
      base = int'(pc >> 2) * 4;
      for (int k = 0; k < 4; k++)
        if (base + k < model_q.size()) w[31-8*k -: 8] = model_q[base+k];
    end
    return w;
  endfunction

  task automatic check_state(input string tag, input logic [31:0] pc);
    i_pc = pc;
    #1;
    check_val({tag, "_instr"}, o_instruction, exp_instr(pc));
    check_val({tag, "_full"}, {31'b0, o_full}, {31'b0, model_q.size() == MEM_BYTES});
    check_val({tag, "_empty"}, {31'b0, o_empty}, {31'b0, model_q.size() == 0});
    check_val({tag, "_wcnt"}, {23'b0, o_word_count}, 32'(model_q.size() / 4));
  endtask

  task automatic write_byte(input logic [7:0] b);
    i_write = 1'b1;
    i_data  = b;
    @(posedge i_clk); #1;
    i_write = 1'b0;
    if (model_q.size() < MEM_BYTES) model_q.push_back(b);
  endtask

  task automatic do_clear(input logic with_write, input logic [7:0] b);
    i_clear = 1'b1;
    i_write = with_write;
    i_data  = b;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    i_write = 1'b0;
    model_q.delete();
  endtask

  initial begin
    i_reset = 1'b0; i_clear = 1'b0; i_write = 1'b0; i_data = 8'h5A; i_pc = 32'h0;
    #3;
    check_state("reset_active", 32'h0);
    check_state("reset_active_pc8", 32'h8);
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b1;
    @(posedge i_clk); #1;
    check_state("after_reset", 32'h0);

    // 1: single word
    write_byte(8'h20); write_byte(8'h01); write_byte(8'h00); write_byte(8'h05);
    check_state("t1", 32'h0);
    check_val("t1_literal", o_instruction, 32'h20010005);

    // 2: three words and address sweep
    do_clear(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) write_byte(8'h11);
    for (int i = 0; i < 4; i++) write_byte(8'h22);
    for (int i = 0; i < 4; i++) write_byte(8'h33);
    check_state("t2_pc0", 32'd0);
    check_state("t2_pc4", 32'd4);
    check_state("t2_pc8", 32'd8);
    check_state("t2_pc9", 32'd9);
    check_val("t2_pc9_literal", o_instruction, 32'h33333333);
    check_state("t2_pc12", 32'd12);

    // 3: fill to capacity, then overflow attempts
    do_clear(1'b0, 8'h00);
    for (int i = 0; i < MEM_BYTES; i++) write_byte(8'hAB);
    write_byte(8'hCD); write_byte(8'hCD);
    check_state("t3_pc252", 32'd252);
    check_val("t3_full_literal", {31'b0, o_full}, 32'd1);
    check_val("t3_wcnt_literal", {23'b0, o_word_count}, 32'd64);
    check_state("t3_pc256", 32'd256);
    check_state("t3_pc_max", 32'hFFFF_FFFC);

    // 4: partial word, then clear beating a simultaneous write
    do_clear(1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) write_byte(8'(i));
    check_state("t4_pc4", 32'd4);
    check_val("t4_pc4_literal", o_instruction, 32'h05060000);
    do_clear(1'b1, 8'h07);
    check_state("t4_clr_pc0", 32'd0);

    // 5: asynchronous reset mid-word
    for (int i = 0; i < 5; i++) write_byte(8'(8'h40 + i));
    #2 i_reset = 1'b0;
    model_q.delete();
    check_state("t5_rst_pc0", 32'd0);
    check_state("t5_rst_pc4", 32'd4);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    write_byte(8'hDE); write_byte(8'hAD); write_byte(8'hBE); write_byte(8'hEF);
    check_state("t5_reload", 32'd0);
    check_val("t5_literal", o_instruction, 32'hDEADBEEF);

    // 6: idle cycles with random data
    for (int i = 0; i < 20; i++) begin
      i_data = 8'($urandom);
      @(posedge i_clk); #1;
      check_state("t6_idle", 32'($urandom_range(0, 7)) << 2);
    end

    // Random mix of writes, clears and fetches
    do_clear(1'b0, 8'h00);
    for (int n = 0; n < 600; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 2) do_clear(1'($urandom), 8'($urandom));
      else if (op < 80) write_byte(8'($urandom));
      else begin
        i_data = 8'($urandom);
        @(posedge i_clk); #1;
      end
      if (n % 4 == 0) check_state("rand", 32'($urandom_range(0, 300)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
